// File: rtl/inst_encoder_pkg.sv
// Shared instruction-set constants for the MIPS encoder/decoder pair.
// Op-select bit positions match the decoder's one-hot output order.
package inst_pkg;

    localparam logic [4:0] IDX_ADD   = 5'd0;
    localparam logic [4:0] IDX_ADDU  = 5'd1;
    localparam logic [4:0] IDX_SUBU  = 5'd2;
    localparam logic [4:0] IDX_SUB   = 5'd3;
    localparam logic [4:0] IDX_AND   = 5'd4;
    localparam logic [4:0] IDX_OR    = 5'd5;
    localparam logic [4:0] IDX_XOR   = 5'd6;
    localparam logic [4:0] IDX_NOR   = 5'd7;
    localparam logic [4:0] IDX_SLT   = 5'd8;
    localparam logic [4:0] IDX_SLTU  = 5'd9;
    localparam logic [4:0] IDX_SLL   = 5'd10;
    localparam logic [4:0] IDX_SRL   = 5'd11;
    localparam logic [4:0] IDX_SRA   = 5'd12;
    localparam logic [4:0] IDX_SLLV  = 5'd13;
    localparam logic [4:0] IDX_SRLV  = 5'd14;
    localparam logic [4:0] IDX_SRAV  = 5'd15;
    localparam logic [4:0] IDX_JR    = 5'd16;
    localparam logic [4:0] IDX_ADDI  = 5'd17;
    localparam logic [4:0] IDX_ADDIU = 5'd18;
    localparam logic [4:0] IDX_ANDI  = 5'd19;
    localparam logic [4:0] IDX_ORI   = 5'd20;
    localparam logic [4:0] IDX_XORI  = 5'd21;
    localparam logic [4:0] IDX_LW    = 5'd22;
    localparam logic [4:0] IDX_SW    = 5'd23;
    localparam logic [4:0] IDX_BEQ   = 5'd24;
    localparam logic [4:0] IDX_BNE   = 5'd25;
    localparam logic [4:0] IDX_SLTI  = 5'd26;
    localparam logic [4:0] IDX_SLTIU = 5'd27;
    localparam logic [4:0] IDX_LUI   = 5'd28;
    localparam logic [4:0] IDX_J     = 5'd29;
    localparam logic [4:0] IDX_JAL   = 5'd30;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_SLTI    = 6'h0A;
    localparam logic [5:0] OPC_SLTIU   = 6'h0B;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Field layout family an op index packs into.
    typedef enum logic [2:0] {
        FMT_R,
        FMT_SHIFT,
        FMT_JR,
        FMT_I,
        FMT_LUI,
        FMT_J
    } op_fmt_e;

    function automatic op_fmt_e fmt_of(logic [4:0] idx);
        if (idx >= IDX_J)      return FMT_J;
        if (idx == IDX_LUI)    return FMT_LUI;
        if (idx >= IDX_ADDI)   return FMT_I;
        if (idx == IDX_JR)     return FMT_JR;
        if (idx >= IDX_SLL && idx <= IDX_SRA) return FMT_SHIFT;
        return FMT_R;
    endfunction

    // Funct for SPECIAL-opcode ops, major opcode for everything else.
    function automatic logic [5:0] code6_of(logic [4:0] idx);
        case (idx)
            IDX_ADD:   return FN_ADD;
            IDX_ADDU:  return FN_ADDU;
            IDX_SUBU:  return FN_SUBU;
            IDX_SUB:   return FN_SUB;
            IDX_AND:   return FN_AND;
            IDX_OR:    return FN_OR;
            IDX_XOR:   return FN_XOR;
            IDX_NOR:   return FN_NOR;
            IDX_SLT:   return FN_SLT;
            IDX_SLTU:  return FN_SLTU;
            IDX_SLL:   return FN_SLL;
            IDX_SRL:   return FN_SRL;
            IDX_SRA:   return FN_SRA;
            IDX_SLLV:  return FN_SLLV;
            IDX_SRLV:  return FN_SRLV;
            IDX_SRAV:  return FN_SRAV;
            IDX_JR:    return FN_JR;
            IDX_ADDI:  return OPC_ADDI;
            IDX_ADDIU: return OPC_ADDIU;
            IDX_ANDI:  return OPC_ANDI;
            IDX_ORI:   return OPC_ORI;
            IDX_XORI:  return OPC_XORI;
            IDX_LW:    return OPC_LW;
            IDX_SW:    return OPC_SW;
            IDX_BEQ:   return OPC_BEQ;
            IDX_BNE:   return OPC_BNE;
            IDX_SLTI:  return OPC_SLTI;
            IDX_SLTIU: return OPC_SLTIU;
            IDX_LUI:   return OPC_LUI;
            IDX_J:     return OPC_J;
            IDX_JAL:   return OPC_JAL;
            default:   return 6'h00;
        endcase
    endfunction

    // True when exactly one bit of the 31 real op positions is set.
    function automatic logic is_onehot31(logic [30:0] v);
        return (v != '0) && ((v & (v - 31'd1)) == '0);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between the program builder and the encoder.
// master = producer/consumer side, slave = the encoder itself.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       inst_code;
    logic [ADDR_W-1:0] inst_addr;
    logic              err_illegal;

    modport master (
        output in_valid, op_sel, rs, rt, rd, shamt, imm, target, out_ready,
        input  in_ready, out_valid, inst_code, inst_addr, err_illegal
    );

    modport slave (
        input  in_valid, op_sel, rs, rt, rd, shamt, imm, target, out_ready,
        output in_ready, out_valid, inst_code, inst_addr, err_illegal
    );
endinterface

// File: rtl/inst_encoder_field_pack.sv
// Combinational packer: lowest set op-select bit picks the layout,
// unused fields are forced to zero so a decoder round-trip is exact.
module inst_field_pack
    import inst_pkg::*;
(
    input  logic [30:0] opSel_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] code_o
);

    logic [4:0] idx;
    logic       found;
    logic [5:0] sel6;

    // Priority-select the lowest op bit and assemble its instruction word.
    always_comb begin
        idx   = IDX_ADD;
        found = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            if (opSel_i[i]) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        sel6   = code6_of(idx);
        code_o = '0;
        if (found) begin
            case (fmt_of(idx))
                FMT_R:     code_o = {OPC_SPECIAL, rs_i, rt_i, rd_i, 5'd0, sel6};
                FMT_SHIFT: code_o = {OPC_SPECIAL, 5'd0, rt_i, rd_i, shamt_i, sel6};
                FMT_JR:    code_o = {OPC_SPECIAL, rs_i, 15'd0, sel6};
                FMT_I:     code_o = {sel6, rs_i, rt_i, imm_i};
                FMT_LUI:   code_o = {sel6, 5'd0, rt_i, imm_i};
                FMT_J:     code_o = {sel6, target_i};
                default:   code_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: one registered output stage with valid/ready on both
// sides and a running byte-address counter for the emitted words.
// Optional macro INST_ENC_ONEHOT_CHECK_EN rejects non-one-hot op selects
// and flags them on err_illegal instead of emitting a word.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h00400000),
    parameter int unsigned       ADDR_STEP = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    inst_encoder_if.slave bus
);

    logic              outValid_q,   outValid_d;
    logic [31:0]       instCode_q,   instCode_d;
    logic [ADDR_W-1:0] instAddr_q,   instAddr_d;
    logic              errIllegal_q, errIllegal_d;
    logic [31:0]       packedCode;
    logic              accept;
    logic              outHandshake;

    inst_field_pack u_pack (
        .opSel_i  (bus.op_sel[30:0]),
        .rs_i     (bus.rs),
        .rt_i     (bus.rt),
        .rd_i     (bus.rd),
        .shamt_i  (bus.shamt),
        .imm_i    (bus.imm),
        .target_i (bus.target),
        .code_o   (packedCode)
    );

`ifdef INST_ENC_ONEHOT_CHECK_EN
    logic opLegal;
    assign opLegal = is_onehot31(bus.op_sel[30:0]) && !bus.op_sel[31];
`else
    logic unusedOpBit31;
    assign unusedOpBit31 = bus.op_sel[31];
`endif

    assign bus.in_ready    = !outValid_q || bus.out_ready;
    assign accept          = bus.in_valid && bus.in_ready;
    assign outHandshake    = outValid_q && bus.out_ready;
    assign bus.out_valid   = outValid_q;
    assign bus.inst_code   = instCode_q;
    assign bus.inst_addr   = instAddr_q;
    assign bus.err_illegal = errIllegal_q;

    // Next-state for the output stage: drain on handshake, load on accept, clr resets the address last.
    always_comb begin
        outValid_d   = outValid_q;
        instCode_d   = instCode_q;
        instAddr_d   = instAddr_q;
        errIllegal_d = 1'b0;
        if (outHandshake) begin
            outValid_d = 1'b0;
            instAddr_d = instAddr_q + ADDR_W'(ADDR_STEP);
        end
        if (accept) begin
`ifdef INST_ENC_ONEHOT_CHECK_EN
            if (opLegal) begin
                outValid_d = 1'b1;
                instCode_d = packedCode;
            end else begin
                errIllegal_d = 1'b1;
            end
`else
            outValid_d = 1'b1;
            instCode_d = packedCode;
`endif
        end
        if (clr) begin
            instAddr_d = BASE_ADDR;
        end
    end

    // Output stage registers; reset drops any held word without replay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q   <= 1'b0;
            instCode_q   <= '0;
            instAddr_q   <= BASE_ADDR;
            errIllegal_q <= 1'b0;
        end else begin
            outValid_q   <= outValid_d;
            instCode_q   <= instCode_d;
            instAddr_q   <= instAddr_d;
            errIllegal_q <= errIllegal_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed spec vectors, backpressure, clr and
// reset cases, then randomized traffic against a transaction-level model.
module tb_inst_encoder;

    localparam logic [31:0] BASE = 32'h00400000;

    logic clk;
    logic rst_n;
    logic clr;

    inst_encoder_if #(.ADDR_W(32)) bus ();

    inst_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    int testsRun;
    int testsFailed;

    logic        expValid;
    logic [31:0] expCode;
    logic [31:0] expAddr;
    logic        expErr;

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rWord(longint rs, longint rt, longint rd, longint sh, longint fn);
        return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn);
    endfunction

    function automatic logic [31:0] iWord(longint opc, longint rs, longint rt, longint imm);
        return 32'(opc * 67108864 + rs * 2097152 + rt * 65536 + imm);
    endfunction

    function automatic logic [31:0] jWord(longint opc, longint tgt);
        return 32'(opc * 67108864 + tgt);
    endfunction

    // MIPS encoding straight from the ISA tables: lowest set op bit wins, none -> nop.
    function automatic logic [31:0] refEncode(logic [31:0] op, logic [4:0] rs, logic [4:0] rt,
                                              logic [4:0] rd, logic [4:0] sh, logic [15:0] imm,
                                              logic [25:0] tgt);
        int k;
        k = -1;
        for (int i = 0; i < 31; i++) begin
            if (op[i] && k < 0) k = i;
        end
        case (k)
            0:  return rWord(rs, rt, rd, 0, 32);
            1:  return rWord(rs, rt, rd, 0, 33);
            2:  return rWord(rs, rt, rd, 0, 35);
            3:  return rWord(rs, rt, rd, 0, 34);
            4:  return rWord(rs, rt, rd, 0, 36);
            5:  return rWord(rs, rt, rd, 0, 37);
            6:  return rWord(rs, rt, rd, 0, 38);
            7:  return rWord(rs, rt, rd, 0, 39);
            8:  return rWord(rs, rt, rd, 0, 42);
            9:  return rWord(rs, rt, rd, 0, 43);
            10: return rWord(0, rt, rd, sh, 0);
            11: return rWord(0, rt, rd, sh, 2);
            12: return rWord(0, rt, rd, sh, 3);
            13: return rWord(rs, rt, rd, 0, 4);
            14: return rWord(rs, rt, rd, 0, 6);
            15: return rWord(rs, rt, rd, 0, 7);
            16: return rWord(rs, 0, 0, 0, 8);
            17: return iWord(8, rs, rt, imm);
            18: return iWord(9, rs, rt, imm);
            19: return iWord(12, rs, rt, imm);
            20: return iWord(13, rs, rt, imm);
            21: return iWord(14, rs, rt, imm);
            22: return iWord(35, rs, rt, imm);
            23: return iWord(43, rs, rt, imm);
            24: return iWord(4, rs, rt, imm);
            25: return iWord(5, rs, rt, imm);
            26: return iWord(10, rs, rt, imm);
            27: return iWord(11, rs, rt, imm);
            28: return iWord(15, 0, rt, imm);
            29: return jWord(2, tgt);
            30: return jWord(3, tgt);
            default: return 32'h00000000;
        endcase
    endfunction

    // Whether an accepted request produces an output word in this build.
    function automatic logic requestEmits(logic [31:0] op);
`ifdef INST_ENC_ONEHOT_CHECK_EN
        return ($countones(op[30:0]) == 1) && !op[31];
`else
        return (op == op);
`endif
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(string tag);
        checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'(expValid));
        checkOutput({tag, ".ready"}, 32'(bus.in_ready), 32'(!expValid || bus.out_ready));
        checkOutput({tag, ".code"}, bus.inst_code, expCode);
        checkOutput({tag, ".addr"}, bus.inst_addr, expAddr);
        checkOutput({tag, ".err"}, 32'(bus.err_illegal), 32'(expErr));
    endtask

    task automatic applyStimulus(logic [31:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                 logic [4:0] sh, logic [15:0] imm, logic [25:0] tgt);
        bus.op_sel   = op;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd       = rd;
        bus.shamt    = sh;
        bus.imm      = imm;
        bus.target   = tgt;
        bus.in_valid = 1'b1;
    endtask

    task automatic idleInputs();
        bus.in_valid = 1'b0;
    endtask

    task automatic modelReset();
        expValid = 1'b0;
        expCode  = 32'h0;
        expAddr  = BASE;
        expErr   = 1'b0;
    endtask

    // Advance one clock from a falling edge, updating the transaction model.
    task automatic stepCycle();
        logic acc;
        logic hs;
        acc = bus.in_valid && (!expValid || bus.out_ready);
        hs  = expValid && bus.out_ready;
        @(posedge clk);
        expErr = 1'b0;
        if (hs) begin
            expValid = 1'b0;
            expAddr  = expAddr + 32'd4;
        end
        if (acc) begin
            if (requestEmits(bus.op_sel)) begin
                expValid = 1'b1;
                expCode  = refEncode(bus.op_sel, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm, bus.target);
            end else begin
                expErr = 1'b1;
            end
        end
        if (clr) expAddr = BASE;
        @(negedge clk);
    endtask

    // Directed steps followed by randomized traffic.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        idleInputs();
        modelReset();

        repeat (2) @(negedge clk);
        checkAll("reset");
        rst_n = 1'b1;
        @(negedge clk);

        bus.out_ready = 1'b1;
        applyStimulus(32'h00000001, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        stepCycle();
        checkAll("add");
        checkOutput("add.word", bus.inst_code, 32'h00221820);
        checkOutput("add.at", bus.inst_addr, 32'h00400000);

        applyStimulus(32'h00000400, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
        stepCycle();
        checkAll("sll");
        checkOutput("sll.word", bus.inst_code, 32'h00011100);
        checkOutput("sll.at", bus.inst_addr, 32'h00400004);

        idleInputs();
        clr = 1'b1;
        stepCycle();
        clr = 1'b0;
        checkAll("clrWins");

        applyStimulus(32'h00400000, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        stepCycle();
        checkOutput("lw.word", bus.inst_code, 32'h8FA80004);
        checkOutput("lw.at", bus.inst_addr, 32'h00400000);
        applyStimulus(32'h20000000, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        stepCycle();
        checkAll("j");
        checkOutput("j.word", bus.inst_code, 32'h08100000);
        checkOutput("j.at", bus.inst_addr, 32'h00400004);

        bus.out_ready = 1'b0;
        applyStimulus(32'h00000010, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkAll("stall");
            checkOutput("stall.held", bus.inst_code, 32'h08100000);
        end
        bus.out_ready = 1'b1;
        stepCycle();
        checkAll("release");
        checkOutput("release.at", bus.inst_addr, 32'h00400008);
        idleInputs();
        stepCycle();
        checkAll("drain");

        applyStimulus(32'h00000003, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        stepCycle();
        checkAll("multiHot");
`ifdef INST_ENC_ONEHOT_CHECK_EN
        checkOutput("multiHot.errPulse", 32'(bus.err_illegal), 32'd1);
`else
        checkOutput("multiHot.asAdd", bus.inst_code, 32'h00221820);
`endif
        idleInputs();
        stepCycle();
        checkAll("multiHot.after");

        applyStimulus(32'h00000000, 5'd9, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h3FFFFFF);
        stepCycle();
        checkAll("zeroSel");
        applyStimulus(32'h80000000, 5'd9, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h3FFFFFF);
        stepCycle();
        checkAll("bit31");
        applyStimulus(32'h10000000, 5'd31, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0);
        stepCycle();
        checkAll("lui");
        applyStimulus(32'h00010000, 5'd31, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        stepCycle();
        checkAll("jr");
        checkOutput("jr.word", bus.inst_code, 32'h03E00008);

        bus.out_ready = 1'b0;
        applyStimulus(32'h00000004, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0);
        stepCycle();
        idleInputs();
        clr = 1'b1;
        stepCycle();
        clr = 1'b0;
        checkAll("clrPending");
        bus.out_ready = 1'b1;
        stepCycle();
        checkAll("clrPending.drain");

        bus.out_ready = 1'b0;
        applyStimulus(32'h00000020, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
        stepCycle();
        idleInputs();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("asyncReset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(32'h00000008, 5'd2, 5'd3, 5'd4, 5'd0, 16'h0, 26'h0);
        stepCycle();
        checkAll("afterReset");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0)
                bus.op_sel = $urandom();
            else
                bus.op_sel = 32'(1) << $urandom_range(0, 30);
            bus.rs        = 5'($urandom());
            bus.rt        = 5'($urandom());
            bus.rd        = 5'($urandom());
            bus.shamt     = 5'($urandom());
            bus.imm       = 16'($urandom());
            bus.target    = 26'($urandom());
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr           = ($urandom_range(0, 15) == 0);
            stepCycle();
            checkAll("rand");
        end
        clr = 1'b0;
        idleInputs();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
